// File: rtl/mult_div_seq_pkg.sv
// Shared constants for the iterative multiply/divide unit: FSM state
// encoding, operation kind and nominal latency.
package mdu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_MULT = 3'd1;
    localparam state_t S_DIV  = 3'd2;
    localparam state_t S_FIX  = 3'd3;
    localparam state_t S_DONE = 3'd4;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MDU_WIDTH = 32;
    localparam int LAT       = MDU_WIDTH + 2;

    // Start-to-done latency for an arbitrary operand width.
    function automatic int lat_for(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Handshake and operand/result bundle of the multiply/divide unit.
// master: the control unit issuing operations; slave: the unit itself.
interface mult_div_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             MultCtrl;
    logic             DivCtrl;
    logic             SignedOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             DivZero;

    modport master (
        output MultCtrl, DivCtrl, SignedOp, A, B,
        input  HI, LO, busy, done, DivZero
    );

    modport slave (
        input  MultCtrl, DivCtrl, SignedOp, A, B,
        output HI, LO, busy, done, DivZero
    );
endinterface

// File: rtl/mult_div_seq_sign_fix.sv
// Two-lane conditional two's-complement negation. Used once on the
// operands (signed -> magnitude) and once on the results (magnitude ->
// signed product / quotient / remainder).
module mdu_sign_fix #(
    parameter int W0 = 33,
    parameter int W1 = 33
) (
    input  logic [W0-1:0] val0,
    input  logic          neg0,
    input  logic [W1-1:0] val1,
    input  logic          neg1,
    output logic [W0-1:0] res0,
    output logic [W1-1:0] res1
);

    // Negate each lane independently when its flag is set.
    always_comb begin
        res0 = val0;
        res1 = val1;
        if (neg0) begin
            res0 = (~val0) + W0'(1);
        end else begin
            res0 = val0;
        end
        if (neg1) begin
            res1 = (~val1) + W1'(1);
        end else begin
            res1 = val1;
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit with its own sequencing FSM.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; the sign is restored in a single FIX cycle before HI/LO are
// written. Start-to-done latency is WIDTH+2 cycles; divide by zero
// finishes in one cycle with DivZero and leaves HI/LO untouched.
// Optional build macro MULT_EARLY_TERM_EN: a multiply leaves the iteration
// phase as soon as the remaining multiplier bits are all zero.
module mult_div_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    mult_div_seq_if.slave bus
);

    state_t               state_r;
    state_t               state_nx_s;
    logic                 op_r;
    logic [2*WIDTH-1:0]   acc_r;       // mult: product; div: {remainder, quotient/dividend}
    logic [2*WIDTH-1:0]   opa_r;       // mult: shifted multiplicand
    logic [WIDTH:0]       opb_r;       // mult: remaining multiplier; div: divisor
    logic [CNT_W-1:0]     cnt_r;
    logic                 neg_res_r;
    logic                 neg_rem_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 divzero_r;

    logic                 neg_a_s;
    logic                 neg_b_s;
    logic [WIDTH:0]       mag_a_s;
    logic [WIDTH:0]       mag_b_s;
    logic                 b_nonzero_s;
    logic                 accept_s;
    logic                 start_mult_s;
    logic                 start_div_s;
    logic                 div_zero_s;
    logic                 cnt_last_s;
    logic                 mult_last_s;
    logic                 mult_skip_s;
    logic [2*WIDTH-1:0]   mult_acc_nx_s;
    logic [WIDTH:0]       div_shift_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_rem_s;
    logic [2*WIDTH-1:0]   div_acc_nx_s;
    logic [2*WIDTH-1:0]   fix_val0_s;
    logic [2*WIDTH-1:0]   fix_res0_s;
    logic [WIDTH-1:0]     fix_res1_s;

    assign neg_a_s     = bus.SignedOp & bus.A[WIDTH-1];
    assign neg_b_s     = bus.SignedOp & bus.B[WIDTH-1];
    assign b_nonzero_s = (bus.B != {WIDTH{1'b0}});

    // Operand magnitudes: sign-extended to WIDTH+1 bits so INT_MIN keeps its value.
    mdu_sign_fix #(
        .W0(WIDTH + 1),
        .W1(WIDTH + 1)
    ) u_sign_in (
        .val0 ({neg_a_s, bus.A}),
        .neg0 (neg_a_s),
        .val1 ({neg_b_s, bus.B}),
        .neg1 (neg_b_s),
        .res0 (mag_a_s),
        .res1 (mag_b_s)
    );

    // Result sign restore: lane 0 is the full product or the quotient, lane 1 the remainder.
    mdu_sign_fix #(
        .W0(2 * WIDTH),
        .W1(WIDTH)
    ) u_sign_out (
        .val0 (fix_val0_s),
        .neg0 (neg_res_r),
        .val1 (acc_r[2*WIDTH-1:WIDTH]),
        .neg1 (neg_rem_r),
        .res0 (fix_res0_s),
        .res1 (fix_res1_s)
    );

    // Start decode: new operations are accepted in IDLE and in the DONE cycle.
    always_comb begin
        accept_s     = (state_r == S_IDLE) || (state_r == S_DONE);
        start_mult_s = 1'b0;
        start_div_s  = 1'b0;
        div_zero_s   = 1'b0;
        if (accept_s) begin
            start_mult_s = bus.MultCtrl;
            start_div_s  = !bus.MultCtrl && bus.DivCtrl && b_nonzero_s;
            div_zero_s   = !bus.MultCtrl && bus.DivCtrl && !b_nonzero_s;
        end else begin
            start_mult_s = 1'b0;
            start_div_s  = 1'b0;
            div_zero_s   = 1'b0;
        end
    end

    // Iteration end detection, with the optional early exit for multiply.
    always_comb begin
        cnt_last_s = (cnt_r == CNT_W'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
        mult_last_s = cnt_last_s || (opb_r[WIDTH:1] == {WIDTH{1'b0}});
        mult_skip_s = (mag_b_s == {(WIDTH + 1){1'b0}});
`else
        mult_last_s = cnt_last_s;
        mult_skip_s = 1'b0;
`endif
    end

    // One shift-add step and one restoring-divide step.
    always_comb begin
        mult_acc_nx_s = acc_r;
        if (opb_r[0]) begin
            mult_acc_nx_s = acc_r + opa_r;
        end else begin
            mult_acc_nx_s = acc_r;
        end
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= opb_r);
        if (div_ge_s) begin
            div_rem_s = div_shift_s[WIDTH-1:0] - opb_r[WIDTH-1:0];
        end else begin
            div_rem_s = div_shift_s[WIDTH-1:0];
        end
        div_acc_nx_s = {div_rem_s, acc_r[WIDTH-2:0], div_ge_s};
    end

    // Lane 0 of the output fix: whole product for multiply, zero-extended quotient for divide.
    always_comb begin
        fix_val0_s = acc_r;
        if (op_r == OP_MULT) begin
            fix_val0_s = acc_r;
        end else begin
            fix_val0_s = {{WIDTH{1'b0}}, acc_r[WIDTH-1:0]};
        end
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_mult_s) begin
                    state_nx_s = mult_skip_s ? S_FIX : S_MULT;
                end else if (start_div_s) begin
                    state_nx_s = S_DIV;
                end else if (div_zero_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_MULT: begin
                if (mult_last_s) begin
                    state_nx_s = S_FIX;
                end else begin
                    state_nx_s = S_MULT;
                end
            end
            S_DIV: begin
                if (cnt_last_s) begin
                    state_nx_s = S_FIX;
                end else begin
                    state_nx_s = S_DIV;
                end
            end
            S_FIX:   state_nx_s = S_DONE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            op_r      <= OP_MULT;
            acc_r     <= {(2 * WIDTH){1'b0}};
            opa_r     <= {(2 * WIDTH){1'b0}};
            opb_r     <= {(WIDTH + 1){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            divzero_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            busy_r    <= (state_nx_s == S_MULT) || (state_nx_s == S_DIV) ||
                         (state_nx_s == S_FIX);
            done_r    <= (state_nx_s == S_DONE);
            divzero_r <= div_zero_s;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_mult_s) begin
                        op_r      <= OP_MULT;
                        acc_r     <= {(2 * WIDTH){1'b0}};
                        opa_r     <= {{(WIDTH - 1){1'b0}}, mag_a_s};
                        opb_r     <= mag_b_s;
                        cnt_r     <= {CNT_W{1'b0}};
                        neg_res_r <= neg_a_s ^ neg_b_s;
                        neg_rem_r <= 1'b0;
                    end else if (start_div_s) begin
                        op_r      <= OP_DIV;
                        acc_r     <= {{WIDTH{1'b0}}, mag_a_s[WIDTH-1:0]};
                        opb_r     <= mag_b_s;
                        cnt_r     <= {CNT_W{1'b0}};
                        neg_res_r <= neg_a_s ^ neg_b_s;
                        neg_rem_r <= neg_a_s;
                    end
                end
                S_MULT: begin
                    acc_r <= mult_acc_nx_s;
                    opa_r <= {opa_r[2*WIDTH-2:0], 1'b0};
                    opb_r <= {1'b0, opb_r[WIDTH:1]};
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                S_DIV: begin
                    acc_r <= div_acc_nx_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                S_FIX: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (op_r == OP_MULT) begin
                        hi_r <= fix_res0_s[2*WIDTH-1:WIDTH];
                        lo_r <= fix_res0_s[WIDTH-1:0];
                    end else begin
                        hi_r <= fix_res1_s;
                        lo_r <= fix_res0_s[WIDTH-1:0];
                    end
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.HI      = hi_r;
    assign bus.LO      = lo_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.DivZero = divzero_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: the driver pushes the expected
// HI/LO/DivZero/latency computed with plain integer arithmetic, and a
// monitor pops and compares whenever done is seen.
module tb_mult_div_seq;

    localparam int W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    exp_t sb_q[$];
    exp_t e_m;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mult_div_seq_if #(.WIDTH(W)) bus ();

    mult_div_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model + driver: drive one start, push the expected outcome.
    task automatic issue(input logic mc, input logic dc, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, q, r;
        logic [63:0] p;
`ifdef MULT_EARLY_TERM_EN
        longint mb;
`endif
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        e.dz  = 1'b0;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.lat = W + 2;
        if (mc) begin
            p = 64'(sa * sb);
            e.hi = p[63:32];
            e.lo = p[31:0];
`ifdef MULT_EARLY_TERM_EN
            mb = (sb < 0) ? -sb : sb;
            e.lat = 2;
            for (int k = 0; k < W; k++) if (mb[k]) e.lat = 3 + k;
`endif
        end else if (b == 32'd0) begin
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end
        m_hi = e.hi;
        m_lo = e.lo;
        bus.MultCtrl = mc;
        bus.DivCtrl  = dc;
        bus.SignedOp = sgn;
        bus.A        = a;
        bus.B        = b;
        e.start      = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        bus.MultCtrl = 1'b0;
        bus.DivCtrl  = 1'b0;
        bus.SignedOp = 1'($urandom_range(0, 1));
        bus.A        = $urandom;
        bus.B        = $urandom;
    endtask

    // Bounded wait for done, checking busy on every intermediate cycle.
    task automatic wait_done(input logic exp_busy);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            chk("busy_during_op", 64'(bus.busy), 64'(exp_busy));
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, n);
        end
    endtask

    // Monitor: compare every done against the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: done=1 with empty scoreboard, required 0");
                end else begin
                    e_m = sb_q.pop_front();
                    chk("hi", 64'(bus.HI), 64'(e_m.hi));
                    chk("lo", 64'(bus.LO), 64'(e_m.lo));
                    chk("divzero", 64'(bus.DivZero), 64'(e_m.dz));
                    chk("latency", 64'(cyc - e_m.start + 1), 64'(e_m.lat));
                    chk("busy_at_done", 64'(bus.busy), 64'd0);
                end
            end else if (bus.DivZero === 1'b1) begin
                total++;
                bad++;
                $display("FAIL stray_divzero: DivZero=1 without done, required 0");
            end
        end
    end

    initial begin
        reset        = 1'b0;
        bus.MultCtrl = 1'b0;
        bus.DivCtrl  = 1'b0;
        bus.SignedOp = 1'b0;
        bus.A        = 32'd0;
        bus.B        = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(bus.HI), 64'd0);
        chk("rst_lo", 64'(bus.LO), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dz", 64'(bus.DivZero), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Test 1: unsigned all-ones squared.
        issue(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1'b1);
        chk("t1_hi", 64'(bus.HI), 64'h00000000FFFFFFFE);
        chk("t1_lo", 64'(bus.LO), 64'h0000000000000001);

        // Test 2: -3*7 signed and unsigned.
        @(negedge clk);
        issue(1'b1, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7);
        wait_done(1'b1);
        chk("t2s_hi", 64'(bus.HI), 64'h00000000FFFFFFFF);
        chk("t2s_lo", 64'(bus.LO), 64'h00000000FFFFFFEB);
        issue(1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 32'd7);
        wait_done(1'b1);
        chk("t2u_hi", 64'(bus.HI), 64'h0000000000000006);
        chk("t2u_lo", 64'(bus.LO), 64'h00000000FFFFFFEB);

        // Test 3: divides, including INT_MIN / -1.
        issue(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(1'b1);
        chk("t3s_lo", 64'(bus.LO), 64'h00000000FFFFFFFD);
        chk("t3s_hi", 64'(bus.HI), 64'h00000000FFFFFFFF);
        issue(1'b0, 1'b1, 1'b0, 32'd7, 32'd2);
        wait_done(1'b1);
        chk("t3u_lo", 64'(bus.LO), 64'd3);
        chk("t3u_hi", 64'(bus.HI), 64'd1);
        issue(1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1'b1);
        chk("t3m_lo", 64'(bus.LO), 64'h0000000080000000);
        chk("t3m_hi", 64'(bus.HI), 64'd0);

        // Test 4: load HI=LO=0x12345678 (641*6700417 = 2^32+1), then divide by zero.
        @(negedge clk);
        issue(1'b1, 1'b0, 1'b0, 32'(64'd641 * 64'd4241943), 32'(64'd6700417 * 64'd72));
        wait_done(1'b1);
        chk("t4_pre_hi", 64'(bus.HI), 64'h0000000012345678);
        chk("t4_pre_lo", 64'(bus.LO), 64'h0000000012345678);
        repeat (2) @(negedge clk);
        issue(1'b0, 1'b1, 1'b1, 32'd55, 32'd0);
        chk("t4_done", 64'(bus.done), 64'd1);
        chk("t4_dz", 64'(bus.DivZero), 64'd1);
        chk("t4_busy", 64'(bus.busy), 64'd0);
        chk("t4_hi", 64'(bus.HI), 64'h0000000012345678);
        chk("t4_lo", 64'(bus.LO), 64'h0000000012345678);
        @(negedge clk);
        chk("t4_done_off", 64'(bus.done), 64'd0);
        chk("t4_dz_off", 64'(bus.DivZero), 64'd0);
        chk("t4_busy_off", 64'(bus.busy), 64'd0);

        // Test 5: reset in the middle of a multiply, then restart.
        issue(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'hFFFFFFFF);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_hi", 64'(bus.HI), 64'd0);
        chk("t5_lo", 64'(bus.LO), 64'd0);
        sb_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(1'b1, 1'b0, 1'b1, 32'd5, 32'd6);
        wait_done(1'b1);
        chk("t5_lo30", 64'(bus.LO), 64'd30);
        chk("t5_hi0", 64'(bus.HI), 64'd0);

        // Test 6: start pulses while busy are ignored; simultaneous start multiplies.
        @(negedge clk);
        issue(1'b1, 1'b0, 1'b0, 32'd1000, 32'hFFFF0000);
        repeat (5) @(negedge clk);
        bus.MultCtrl = 1'b1;
        bus.DivCtrl  = 1'b1;
        bus.A        = 32'd3;
        bus.B        = 32'd4;
        @(negedge clk);
        bus.MultCtrl = 1'b0;
        bus.DivCtrl  = 1'b0;
        wait_done(1'b1);
        repeat (40) @(negedge clk);
        issue(1'b1, 1'b1, 1'b1, 32'hFFFFFFFD, 32'd7);
        wait_done(1'b1);
        chk("t6_hi", 64'(bus.HI), 64'h00000000FFFFFFFF);
        chk("t6_lo", 64'(bus.LO), 64'h00000000FFFFFFEB);
`ifdef MULT_EARLY_TERM_EN
        @(negedge clk);
        issue(1'b1, 1'b0, 1'b0, 32'd9, 32'd1);
        wait_done(1'b1);
        chk("t6_et_lo", 64'(bus.LO), 64'd9);
`endif

        // Randomised mix with corner operands and back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        is_mult;
            logic        sgn;
            ra      = $urandom;
            rb      = $urandom;
            is_mult = 1'($urandom_range(0, 1));
            sgn     = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = rb & 32'h000000FF;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(is_mult, !is_mult, sgn, ra, rb);
            wait_done(is_mult || (rb != 32'd0));
        end

        repeat (5) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
